// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode type seen by the operation memory, the
// dispatcher and the FPU core, plus default datapath sizes.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/op_dispatch.sv
// Walks the operation memory, issues each entry to the FPU over valid/ready
// and writes every returned result back to the result store at its index.
module op_dispatch
  import fpu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] address,
  input  op_t               op,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  output logic              fpu_valid,
  input  logic              fpu_ready,
  output op_t               fpu_op,
  output logic [WIDTH-1:0]  fpu_a,
  output logic [WIDTH-1:0]  fpu_b,
  input  logic              res_valid,
  input  logic [WIDTH-1:0]  res,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [WIDTH-1:0]  res_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  // One bit wider than the address so a full-memory run ends at the top entry
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] last_q;
  logic [ADDR_W:0] cnt_clamp;
  logic            is_last;

  assign cnt_clamp = (count > MAX_CNT) ? MAX_CNT : count;
  assign is_last   = (idx_q == last_q);

  assign address   = idx_q[ADDR_W-1:0];
  assign fpu_valid = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: if (fpu_ready) state_d = S_WAIT;
      S_WAIT:  if (res_valid) state_d = is_last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      last_q   <= '0;
      fpu_op   <= OP_ADD;
      fpu_a    <= '0;
      fpu_b    <= '0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_we <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_q  <= '0;
            last_q <= cnt_clamp - ONE;
          end
        end
        S_FETCH: begin
          fpu_op <= op;
          fpu_a  <= opA;
          fpu_b  <= opB;
        end
        S_WAIT: begin
          if (res_valid) begin
            res_we   <= 1'b1;
            res_addr <= idx_q[ADDR_W-1:0];
            res_data <= res;
            if (!is_last) idx_q <= idx_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_dispatch.sv
// Directed bench for op_dispatch: memory is a bench-side table, the FPU side
// is driven step by step from the main sequence.
module tb_op_dispatch;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, fpu_ready, res_valid;
  logic [8:0]  count;
  logic [7:0]  address, res_addr;
  op_t         op, fpu_op;
  logic [15:0] opA, opB, fpu_a, fpu_b, res, res_data;
  logic        fpu_valid, res_we, busy, done;

  op_t         mem_op [256];
  logic [15:0] mem_a  [256];
  logic [15:0] mem_b  [256];

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_hs = 0, n_done = 0;

  assign op  = mem_op[address];
  assign opA = mem_a[address];
  assign opB = mem_b[address];

  op_dispatch #(.WIDTH(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .address(address), .op(op), .opA(opA), .opB(opB),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .res_valid(res_valid), .res(res),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_we) n_wr++;
    if (done) n_done++;
    if (fpu_valid && fpu_ready) n_hs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in the FETCH cycle of entry idx; leaves in the next FETCH, or
  // (last entry) in the first IDLE cycle after done.
  task automatic do_op(input int idx, input logic last, input logic [1:0] eop,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] r);
    chk("fetch_addr", 32'(address), 32'(idx[7:0]));
    step();
    chk("issue_valid", 32'(fpu_valid), 32'd1);
    chk("issue_op", 32'(fpu_op), 32'(eop));
    chk("issue_a", 32'(fpu_a), 32'(ea));
    chk("issue_b", 32'(fpu_b), 32'(eb));
    step();
    chk("wait_valid", 32'(fpu_valid), 32'd0);
    res_valid = 1'b1;
    res = r;
    step();
    res_valid = 1'b0;
    chk("wr_we", 32'(res_we), 32'd1);
    chk("wr_addr", 32'(res_addr), 32'(idx[7:0]));
    chk("wr_data", 32'(res_data), 32'(r));
    chk("wr_done", 32'(done), 32'(last));
    if (last) begin
      step();
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int wr0, hs0, dn0;
    logic [15:0] cap_a, cap_b;
    logic [1:0]  cap_op;
    for (int i = 0; i < 256; i++) begin
      mem_op[i] = OP_ADD; mem_a[i] = '0; mem_b[i] = '0;
    end
    reset = 1'b1; start = 1'b0; count = '0; fpu_ready = 1'b1;
    res_valid = 1'b0; res = '0;
    step(); step();

    // Reset values
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_valid", 32'(fpu_valid), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_fpu_a", 32'(fpu_a), 32'd0);
    chk("rst_fpu_b", 32'(fpu_b), 32'd0);
    chk("rst_res_we", 32'(res_we), 32'd0);
    chk("rst_res_addr", 32'(res_addr), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    // count=3, ready tied high
    mem_op[0] = OP_ADD; mem_a[0] = 16'h3C00; mem_b[0] = 16'h4000;
    mem_op[1] = OP_MUL; mem_a[1] = 16'h4200; mem_b[1] = 16'hC400;
    mem_op[2] = OP_DIV; mem_a[2] = 16'h4500; mem_b[2] = 16'h3800;
    wr0 = n_wr; hs0 = n_hs; dn0 = n_done;
    count = 9'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("c3_busy", 32'(busy), 32'd1);
    chk("c3_first_valid", 32'(fpu_valid), 32'd0);
    do_op(0, 1'b0, 2'd0, 16'h3C00, 16'h4000, 16'h4200);
    do_op(1, 1'b0, 2'd2, 16'h4200, 16'hC400, 16'hCA00);
    do_op(2, 1'b1, 2'd3, 16'h4500, 16'h3800, 16'h4900);
    chk("c3_writes", 32'(n_wr - wr0), 32'd3);
    chk("c3_handshakes", 32'(n_hs - hs0), 32'd3);
    chk("c3_dones", 32'(n_done - dn0), 32'd1);

    // count=0: straight to done
    wr0 = n_wr; hs0 = n_hs;
    count = 9'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("c0_done", 32'(done), 32'd1);
    chk("c0_valid", 32'(fpu_valid), 32'd0);
    chk("c0_we", 32'(res_we), 32'd0);
    step();
    chk("c0_done_low", 32'(done), 32'd0);
    chk("c0_busy_low", 32'(busy), 32'd0);
    chk("c0_no_writes", 32'(n_wr - wr0), 32'd0);
    chk("c0_no_hs", 32'(n_hs - hs0), 32'd0);

    // Backpressure: ready low for 5 ISSUE cycles
    mem_op[0] = OP_SUB; mem_a[0] = 16'h1234; mem_b[0] = 16'hABCD;
    hs0 = n_hs;
    fpu_ready = 1'b0; count = 9'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("bp_addr", 32'(address), 32'd0);
    step();
    cap_op = fpu_op; cap_a = fpu_a; cap_b = fpu_b;
    chk("bp_latched_a", 32'(cap_a), 32'h1234);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(fpu_valid), 32'd1);
      chk("bp_op_hold", 32'(fpu_op), 32'(cap_op));
      chk("bp_a_hold", 32'(fpu_a), 32'(cap_a));
      chk("bp_b_hold", 32'(fpu_b), 32'(cap_b));
      step();
    end
    fpu_ready = 1'b1;
    chk("bp_valid_last", 32'(fpu_valid), 32'd1);
    step();
    chk("bp_valid_drop", 32'(fpu_valid), 32'd0);
    chk("bp_one_hs", 32'(n_hs - hs0), 32'd1);
    res_valid = 1'b1; res = 16'h5555;
    step();
    res_valid = 1'b0;
    chk("bp_wr_data", 32'(res_data), 32'h5555);
    chk("bp_done", 32'(done), 32'd1);
    step();

    // Spurious res_valid in ISSUE and start mid-run
    mem_op[0] = OP_ADD; mem_a[0] = 16'h0101; mem_b[0] = 16'h0202;
    mem_op[1] = OP_DIV; mem_a[1] = 16'h0303; mem_b[1] = 16'h0404;
    wr0 = n_wr; hs0 = n_hs;
    fpu_ready = 1'b0; count = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    res_valid = 1'b1; res = 16'hDEAD; start = 1'b1; count = 9'd5;
    step();
    res_valid = 1'b0; start = 1'b0; count = 9'd2;
    chk("sp_no_we", 32'(res_we), 32'd0);
    chk("sp_still_issue", 32'(fpu_valid), 32'd1);
    fpu_ready = 1'b1;
    step();
    res_valid = 1'b1; res = 16'h0F0F; start = 1'b1;
    step();
    res_valid = 1'b0; start = 1'b0;
    chk("sp_wr_addr0", 32'(res_addr), 32'd0);
    chk("sp_wr_data0", 32'(res_data), 32'h0F0F);
    do_op(1, 1'b1, 2'd3, 16'h0303, 16'h0404, 16'hF0F0);
    chk("sp_writes", 32'(n_wr - wr0), 32'd2);
    chk("sp_hs", 32'(n_hs - hs0), 32'd2);

    // Reset in WAIT of entry 2
    for (int i = 0; i < 4; i++) begin
      mem_op[i] = op_t'(2'(i)); mem_a[i] = 16'(16'h100 + i); mem_b[i] = 16'(16'h200 + i);
    end
    wr0 = n_wr;
    count = 9'd4; start = 1'b1;
    step();
    start = 1'b0;
    do_op(0, 1'b0, 2'd0, 16'h0100, 16'h0200, 16'hAAAA);
    do_op(1, 1'b0, 2'd1, 16'h0101, 16'h0201, 16'hBBBB);
    step();
    step();
    chk("rm_in_wait", 32'(fpu_valid), 32'd0);
    reset = 1'b1; res_valid = 1'b1; res = 16'hCCCC;
    step();
    reset = 1'b0; res_valid = 1'b0;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_we", 32'(res_we), 32'd0);
    chk("rm_addr", 32'(address), 32'd0);
    chk("rm_fpu_a", 32'(fpu_a), 32'd0);
    chk("rm_res_data", 32'(res_data), 32'd0);
    chk("rm_res_addr", 32'(res_addr), 32'd0);
    step();
    chk("rm_writes", 32'(n_wr - wr0), 32'd2);
    count = 9'd1; start = 1'b1;
    step();
    start = 1'b0;
    do_op(0, 1'b1, 2'd0, 16'h0100, 16'h0200, 16'h1111);

    // count=256: full memory, no wrap
    for (int i = 0; i < 256; i++) begin
      mem_op[i] = op_t'(2'(i)); mem_a[i] = 16'(i * 3 + 1); mem_b[i] = ~16'(i);
    end
    wr0 = n_wr; hs0 = n_hs; dn0 = n_done;
    count = 9'd256; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++)
      do_op(i, (i == 255), 2'(i), 16'(i * 3 + 1), ~16'(i), 16'(i * 7 + 16'h1000));
    chk("full_last_addr", 32'(res_addr), 32'd255);
    chk("full_writes", 32'(n_wr - wr0), 32'd256);
    chk("full_hs", 32'(n_hs - hs0), 32'd256);
    chk("full_dones", 32'(n_done - dn0), 32'd1);
    step();
    chk("full_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
